// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port.
// Round-robin arbitration shares the single write port between the ALU and
// memory-load requesters. The write drive is registered with one cycle of
// latency. A pending-write scoreboard lets issue logic detect RAW hazards.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_rd,
  input  logic [AW-1:0] RS1,
  input  logic [AW-1:0] RS2,
  output logic          pend_rs1,
  output logic          pend_rs2,
  output logic [AW-1:0] RD,
  output logic [DW-1:0] C,
  output logic          w
);

  localparam int NREG = 2 ** AW;

  // Which requester won the most recent acceptance. On a tie, the other
  // requester wins next.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  grant_t          last_grant_reg, last_grant_next;
  logic [NREG-1:0] pend_reg, pend_next;
  logic [NREG-1:0] set_mask, clr_mask;
  logic            grant_alu, grant_mem;
  logic            accept;
  logic [AW-1:0]   acc_rd;
  logic [DW-1:0]   acc_data;
  logic            wr_en;

  // Arbitration and selection of the accepted request; no grants while in reset
  always_comb begin
    grant_alu       = 1'b0;
    grant_mem       = 1'b0;
    last_grant_next = last_grant_reg;
    if (!reset) begin
      if (alu_valid && (!mem_valid || last_grant_reg == GRANT_MEM))
        grant_alu = 1'b1;
      else if (mem_valid)
        grant_mem = 1'b1;
    end
    if (grant_alu)
      last_grant_next = GRANT_ALU;
    else if (grant_mem)
      last_grant_next = GRANT_MEM;
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign accept    = grant_alu | grant_mem;
  assign acc_rd    = grant_mem ? mem_rd   : alu_rd;
  assign acc_data  = grant_mem ? mem_data : alu_data;
  // Register 0 is hardwired. Accept the request but never write it.
  assign wr_en     = accept && (acc_rd != '0);

  // Per-register reservation set and completion clear masks (entry 0 is never tracked)
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign set_mask[gi] = 1'b0;
        assign clr_mask[gi] = 1'b0;
      end else begin : g_reg
        assign set_mask[gi] = rsv_valid && (rsv_rd == AW'(gi));
        assign clr_mask[gi] = accept && (acc_rd == AW'(gi));
      end
    end
  endgenerate

  // A new reservation supersedes a completing write to the same register
  assign pend_next = (pend_reg & ~clr_mask) | set_mask;

  // Hazard lookup reads registered scoreboard state only (no same-cycle bypass)
  assign pend_rs1 = pend_reg[RS1] & (RS1 != '0);
  assign pend_rs2 = pend_reg[RS2] & (RS2 != '0);

  // Arbiter history and scoreboard state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_reg <= GRANT_MEM;
      pend_reg       <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      pend_reg       <= pend_next;
    end
  end

  // Registered write-port drive; address and data hold when no write is issued
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w  <= 1'b0;
      RD <= '0;
      C  <= '0;
    end else begin
      w <= wr_en;
      if (wr_en) begin
        RD <= acc_rd;
        C  <= acc_data;
      end
    end
  end

endmodule
